// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Each operation takes 33 clocks: 32 shift-add or restoring-divide steps on magnitudes, then one sign-fix step.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 sa_q, sa_d, sb_q, sb_d, div_q, div_d, dz_q, dz_d;

  logic                 op_signed;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       mul_sum, div_r;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    dz_d    = dz_q;

    op_signed = ~op[0];
    rs_mag    = cond_neg(rs_val, op_signed & rs_val[WIDTH-1]);
    rt_mag    = cond_neg(rt_val, op_signed & rt_val[WIDTH-1]);

    // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_r   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge  = div_r >= {1'b0, b_q};
    div_rem = div_r[WIDTH-1:0] - b_q;

    prod_fix = cond_neg_wide(acc_q, sa_q ^ sb_q);
    quo_fix  = dz_q ? '1 : cond_neg(acc_q[WIDTH-1:0], sa_q ^ sb_q);
    rem_fix  = cond_neg(acc_q[2*WIDTH-1:WIDTH], sa_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = op_signed & rs_val[WIDTH-1];
          sb_d    = op_signed & rt_val[WIDTH-1];
          div_d   = op[1];
          dz_d    = op[1] & (rt_val == '0);
          acc_d   = op[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
          b_d     = op[1] ? rt_mag : rs_mag;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      S_RUN: begin
        if (div_q)
          acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                         : {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/accumulator path is only consumed after a start, so it carries no reset
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    b_q   <= b_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    div_q <= div_d;
    dz_q  <= dz_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (plus one more unless b2b).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, input bit with_mtlo, input bit b2b);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int n, bc;
    hi0 = hi;
    lo0 = lo;
    exp = model(o, a, b);
    start = 1'b1; op = o; rs_val = a; rt_val = b; mtlo = with_mtlo;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; rs_val = $urandom; rt_val = $urandom;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (poke && n == 10) begin
        start = 1'b1; op = 2'b11; rs_val = 32'hAAAA; rt_val = 32'd3; mthi = 1'b1;
      end
      if (n == 11) begin start = 1'b0; mthi = 1'b0; end
      if (n == 20) begin
        check_eq("hold_hi", {32'd0, hi}, {32'd0, hi0});
        check_eq("hold_lo", {32'd0, lo}, {32'd0, lo0});
      end
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, 33);
    check_eq("busy_cycles", bc, 33);
    check_eq("busy_at_done", {63'd0, busy}, 64'd0);
    check_eq("hilo", {hi, lo}, exp);
    if (!b2b) begin
      @(negedge clk);
      check_eq("done_pulse", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    int dcnt;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_busy", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_hilo", {hi, lo}, 64'd0);
    check_eq("idle_busy", {62'd0, busy, done}, 64'd0);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    check_eq("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 0, 0, 0);
    check_eq("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 0, 0);
    check_eq("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'b11, 32'h00001234, 32'h0, 0, 0, 0);
    check_eq("divu_zero", {hi, lo}, 64'h00001234_FFFFFFFF);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    check_eq("div_ovf", {hi, lo}, 64'h00000000_80000000);
    do_op(2'b10, 32'h80000005, 32'h0, 0, 0, 0);
    check_eq("div_zero_neg", {hi, lo}, 64'h80000005_FFFFFFFF);

    do_op(2'b01, 32'd3, 32'd5, 1, 0, 0);
    check_eq("ignore_busy", {hi, lo}, 64'd15);

    rs_val = 32'h55; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check_eq("mtlo", {hi, lo}, 64'h55);
    rs_val = 32'h77; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check_eq("mthi_mtlo", {hi, lo}, {32'h77, 32'h77});

    do_op(2'b01, 32'd2, 32'd2, 0, 1, 0);
    check_eq("start_beats_mtlo", {hi, lo}, 64'd4);

    do_op(2'b01, 32'd7, 32'd6, 0, 0, 1);
    do_op(2'b10, 32'hFFFFFF9C, 32'd7, 0, 0, 0);
    check_eq("b2b", {hi, lo}, {32'hFFFFFFFE, 32'hFFFFFFF2});

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op(ro, ra, rb, 0, 0, 0);
    end

    start = 1'b1; op = 2'b11; rs_val = 32'd1000; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midop_rst_hilo", {hi, lo}, 64'd0);
    check_eq("midop_rst_busy", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check_eq("no_done_after_rst", dcnt, 0);
    check_eq("hilo_after_rst", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
